// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add sequencer wrapped around an external 4-bit ripple-carry
// adder. Accepts wide operands, walks them through the adder one nibble per
// cycle (LSB first) while chaining the carry, then presents the result.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready high, waiting for an operand handshake
//   RUN   | feeding nibble idx to the adder, capturing S/Cout each edge
//   DONE  | out_valid high, result held until out_ready
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      nib_a, nib_b;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  // Adder drive: only active in RUN, quiet (all zero) otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = nib_a;
      add_b   = nib_b;
      add_cin = (idx_q == '0) ? cin_q : carry_q;
    end
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = op_cin;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[4*i +: 4] = add_s;
          end
        end
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // The MSB of the sum is add_s[3] this cycle, so overflow can be
          // registered together with the last nibble.
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake flags and result outputs come straight from registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    carry_out = cout_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl with a behavioural 4-bit adder in the loop.
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int accept_cyc = 0;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // The 4-bit ripple-carry adder the sequencer wraps.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word addition. Returns {overflow, carry, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  // Carry into nibble i: carry out of the low 4*i bits of a+b+cin.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int i);
    logic [63:0] m;
    logic [63:0] s;
    if (i == 0) return cin;
    m = (64'd1 << (4 * i)) - 64'd1;
    s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    return s[4*i];
  endfunction

  function automatic logic [3:0] nib(input logic [W-1:0] v, input int i);
    logic [W-1:0] t;
    t = v >> (4 * i);
    return t[3:0];
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
    end
    tick();
    accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Walk the RUN cycles checking adder drive, then check the DONE result.
  task automatic run_phase(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL run_flags[%0d]: out_valid=%b in_ready=%b expected 0 0", i, out_valid,
                 in_ready);
      end
      n_vec++;
      if (add_a !== nib(a, i) || add_b !== nib(b, i)) begin
        n_err++;
        $display("FAIL run_nibbles[%0d]: add_a=%h add_b=%h expected %h %h", i, add_a, add_b,
                 nib(a, i), nib(b, i));
      end
      n_vec++;
      if (add_cin !== carry_into(a, b, cin, i)) begin
        n_err++;
        $display("FAIL run_cin[%0d]: add_cin=%b expected %b", i, add_cin,
                 carry_into(a, b, cin, i));
      end
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency: out_valid=%b expected 1 after %0d cycles", out_valid, N);
    end
    n_vec++;
    if (sum !== es || carry_out !== ec || overflow !== eo) begin
      n_err++;
      $display("FAIL result: sum=%h cout=%b ovf=%b expected %h %b %b", sum, carry_out,
               overflow, es, ec, eo);
    end
    n_vec++;
    if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
      n_err++;
      $display("FAIL done_adder_idle: add_a=%h add_b=%h add_cin=%b expected 0 0 0", add_a,
               add_b, add_cin);
    end
  endtask

  task automatic finish_op(input int hold, input logic [W-1:0] es);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || sum !== es) begin
        n_err++;
        $display("FAIL hold: out_valid=%b sum=%h expected 1 %h", out_valid, sum, es);
      end
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL out_handshake: out_valid=%b in_ready=%b expected 0 1", out_valid,
               in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || carry_out !== 1'b0 ||
        overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b vld=%b sum=%h cout=%b ovf=%b expected 1 0 0 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    n_vec++;
    if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
      n_err++;
      $display("FAIL reset_adder: add_a=%h add_b=%h add_cin=%b expected 0", add_a, add_b,
               add_cin);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h00FF};
    logic [W-1:0] tb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h8000, 16'h0000};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [5] = '{16'h2233, 16'h0000, 16'h8000, 16'h0000, 16'h0100};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i], tc[i]);
      run_phase(ta[i], tb[i], tc[i], es[i], ec[i], eo[i]);
      finish_op(0, es[i]);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a0, b0, a1, b1;
    logic [W+1:0] r0, r1;
    a0 = 16'h4321; b0 = 16'h1111;
    a1 = 16'hA5A5; b1 = 16'h5A5A;
    r0 = ref_add(a0, b0, 1'b1);
    r1 = ref_add(a1, b1, 1'b0);
    out_ready = 1'b0;
    start_op(a0, b0, 1'b1);
    run_phase(a0, b0, 1'b1, r0[W-1:0], r0[W], r0[W+1]);
    in_valid = 1'b1;
    op_a     = a1;
    op_b     = b1;
    op_cin   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== r0[W-1:0]) begin
        n_err++;
        $display("FAIL stall[%0d]: vld=%b rdy=%b sum=%h expected 1 0 %h", k, out_valid,
                 in_ready, sum, r0[W-1:0]);
      end
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    run_phase(a1, b1, 1'b0, r1[W-1:0], r1[W], r1[W+1]);
    finish_op(0, r1[W-1:0]);
  endtask

  task automatic test_reset_mid_run();
    logic [W+1:0] r;
    start_op(16'h1234, 16'h0FFF, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || carry_out !== 1'b0 ||
        overflow !== 1'b0) begin
      n_err++;
      $display("FAIL abort_outputs: rdy=%b vld=%b sum=%h cout=%b ovf=%b expected 1 0 0 0 0",
               in_ready, out_valid, sum, carry_out, overflow);
    end
    n_vec++;
    if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0) begin
      n_err++;
      $display("FAIL abort_adder: add_a=%h add_b=%h add_cin=%b expected 0", add_a, add_b,
               add_cin);
    end
    rst_n = 1'b1;
    for (int k = 0; k < N + 3; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_valid[%0d]: out_valid=%b expected 0", k, out_valid);
      end
    end
    r = ref_add(16'h0001, 16'h0001, 1'b0);
    start_op(16'h0001, 16'h0001, 1'b0);
    run_phase(16'h0001, 16'h0001, 1'b0, r[W-1:0], r[W], r[W+1]);
    finish_op(0, r[W-1:0]);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    logic [W+1:0] r;
    for (int t = 0; t < 25; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      r = ref_add(a, b, c);
      start_op(a, b, c);
      run_phase(a, b, c, r[W-1:0], r[W], r[W+1]);
      finish_op(int'($urandom_range(0, 2)), r[W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [W+1:0] r;
    int           prev;
    out_ready = 1'b1;
    prev = 0;
    for (int t = 0; t < 4; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      r = ref_add(a, b, 1'b0);
      start_op(a, b, 1'b0);
      if (t > 0) begin
        n_vec++;
        if (accept_cyc - prev !== N + 2) begin
          n_err++;
          $display("FAIL throughput: period=%0d expected %0d", accept_cyc - prev, N + 2);
        end
      end
      prev = accept_cyc;
      run_phase(a, b, 1'b0, r[W-1:0], r[W], r[W+1]);
      out_ready = 1'b1;
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_handshake: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
